// File: rtl/fpu_ss_compressor.sv
// Compresses RV32F FLW/FSW into C.FLW/C.FLWSP/C.FSW/C.FSWSP and buffers the result in a small FIFO.
// Optional popped-entry statistics counters are enabled with `define FPU_SS_COMPRESSOR_STATS_EN.
module fpu_ss_compressor #(
  parameter int DEPTH = 2,
  parameter bit SP_EN = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [31:0]                  in_instr_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_instr_o,
  output logic                         out_compressed_o,
`ifdef FPU_SS_COMPRESSOR_STATS_EN
  output logic [31:0]                  stat_total_o,
  output logic [31:0]                  stat_comp_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  // Handshake: a transfer happens on a side only in a cycle where its valid and ready are both 1;
  // in_ready_o depends on registered occupancy only, and a flush cycle suppresses both transfers.

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic        is_flw, is_fsw;
  logic [11:0] imm;
  logic        imm_ok_c, imm_ok_sp, sp_base;
  logic        rd_c, rs1_c, rs2_c;
  logic [15:0] c16;
  logic        enc_comp;
  logic [32:0] enc_entry;

  assign opc    = in_instr_i[6:0];
  assign f3     = in_instr_i[14:12];
  assign rd     = in_instr_i[11:7];
  assign rs1    = in_instr_i[19:15];
  assign rs2    = in_instr_i[24:20];
  assign is_flw = (opc == 7'b0000111) && (f3 == 3'b010);
  assign is_fsw = (opc == 7'b0100111) && (f3 == 3'b010);
  assign imm    = is_fsw ? {in_instr_i[31:25], in_instr_i[11:7]} : in_instr_i[31:20];

  assign imm_ok_c  = (imm[1:0] == 2'b00) && (imm[11:7] == 5'd0);
  assign imm_ok_sp = (imm[1:0] == 2'b00) && (imm[11:8] == 4'd0);
  assign sp_base   = SP_EN && (rs1 == 5'd2);
  assign rd_c      = (rd[4:3] == 2'b01);
  assign rs1_c     = (rs1[4:3] == 2'b01);
  assign rs2_c     = (rs2[4:3] == 2'b01);

  always_comb begin
    c16      = 16'h0000;
    enc_comp = 1'b0;
    if (is_flw) begin
      if (rd_c && rs1_c && imm_ok_c) begin
        c16      = {3'b011, imm[5:3], rs1[2:0], imm[2], imm[6], rd[2:0], 2'b00};
        enc_comp = 1'b1;
      end else if (sp_base && imm_ok_sp) begin
        c16      = {3'b011, imm[5], rd, imm[4:2], imm[7:6], 2'b10};
        enc_comp = 1'b1;
      end
    end else if (is_fsw) begin
      if (rs2_c && rs1_c && imm_ok_c) begin
        c16      = {3'b111, imm[5:3], rs1[2:0], imm[2], imm[6], rs2[2:0], 2'b00};
        enc_comp = 1'b1;
      end else if (sp_base && imm_ok_sp) begin
        c16      = {3'b111, imm[5:2], imm[7:6], rs2, 2'b10};
        enc_comp = 1'b1;
      end
    end
  end

  assign enc_entry = enc_comp ? {1'b1, 16'h0000, c16} : {1'b0, in_instr_i};

  logic [32:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          full, push, pop;

  assign full        = (count_q == LW'(DEPTH));
  assign in_ready_o  = !full;
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;
  assign level_o     = count_q;

  // Outputs read as zero whenever nothing valid sits at the head.
  assign out_instr_o      = out_valid_o ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign out_compressed_o = out_valid_o && mem_q[rd_ptr_q][32];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the occupancy count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= enc_entry;
  end

`ifdef FPU_SS_COMPRESSOR_STATS_EN
  logic [31:0] stat_total_q, stat_comp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_total_q <= '0;
      stat_comp_q  <= '0;
    end else if (pop) begin
      if (stat_total_q != 32'hFFFF_FFFF) stat_total_q <= stat_total_q + 1'b1;
      if (out_compressed_o && (stat_comp_q != 32'hFFFF_FFFF)) stat_comp_q <= stat_comp_q + 1'b1;
    end
  end

  assign stat_total_o = stat_total_q;
  assign stat_comp_o  = stat_comp_q;
`endif

endmodule

// File: tb/tb_fpu_ss_compressor.sv
// Directed bench for fpu_ss_compressor: expected entries are queued at issue time and
// checked by independent monitors whenever a DUT pops an output.
module tb_fpu_ss_compressor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_comp;
  logic [31:0] out_instr;
  logic [1:0]  level;

  logic        in_valid2 = 1'b0;
  logic [31:0] in_instr2 = 32'h0;
  logic        in_ready2, out_valid2, out_comp2;
  logic [31:0] out_instr2;
  logic [1:0]  level2;

`ifdef FPU_SS_COMPRESSOR_STATS_EN
  logic [31:0] st_total, st_comp, st_total2, st_comp2;
`endif

  logic [32:0] exp_q[$];
  logic [32:0] exp_q2[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fpu_ss_compressor #(.DEPTH(2), .SP_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr),
    .out_compressed_o(out_comp),
`ifdef FPU_SS_COMPRESSOR_STATS_EN
    .stat_total_o(st_total), .stat_comp_o(st_comp),
`endif
    .level_o(level)
  );

  fpu_ss_compressor #(.DEPTH(2), .SP_EN(1'b0)) dut_nosp (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_instr_i(in_instr2),
    .out_valid_o(out_valid2), .out_ready_i(1'b1), .out_instr_o(out_instr2),
    .out_compressed_o(out_comp2),
`ifdef FPU_SS_COMPRESSOR_STATS_EN
    .stat_total_o(st_total2), .stat_comp_o(st_comp2),
`endif
    .level_o(level2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: compare every popped entry against the head of its expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", out_instr, 32'hDEAD_DEAD);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("out_instr", out_instr, e[31:0]);
        check("out_compressed", {31'h0, out_comp}, {31'h0, e[32]});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid2) begin
      if (exp_q2.size() == 0) begin
        check("nosp_unexpected_output", out_instr2, 32'hDEAD_DEAD);
      end else begin
        logic [32:0] e;
        e = exp_q2.pop_front();
        check("nosp_out_instr", out_instr2, e[31:0]);
        check("nosp_out_compressed", {31'h0, out_comp2}, {31'h0, e[32]});
      end
    end
  end

  // Drives one instruction from just after a posedge; returns just after its accepting edge.
  task automatic send(input logic [31:0] instr, input logic [31:0] exp_instr, input logic exp_c);
    int waited = 0;
    in_valid = 1'b1;
    in_instr = instr;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'h0, 32'h1);
    end else begin
      exp_q.push_back({exp_c, exp_instr});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [31:0] instr, input logic [31:0] exp_instr, input logic exp_c);
    in_valid2 = 1'b1;
    in_instr2 = instr;
    @(negedge clk);
    exp_q2.push_back({exp_c, exp_instr});
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || exp_q2.size() != 0) && waited < 100) begin
      waited++;
      @(posedge clk); #1;
    end
    check("drain_remaining", exp_q.size() + exp_q2.size(), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'h0, out_valid}, 32'd0);
    check("reset_out_instr", out_instr, 32'h0);
    check("reset_out_compressed", {31'h0, out_comp}, 32'd0);
    check("reset_level", {30'h0, level}, 32'd0);
    check("reset_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Single-entry latency: visible at the head the cycle after accept.
    out_ready = 1'b0;
    send(32'h00C52487, 32'h0000_6544, 1'b1);
    @(negedge clk);
    check("latency_out_valid", {31'h0, out_valid}, 32'd1);
    check("latency_level", {30'h0, level}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Encoding vectors, SP_EN=1 and SP_EN=0 side by side.
    fork
      begin
        send(32'h00512427, 32'h0000_E416, 1'b1);  // FSW f5,8(x2) -> C.FSWSP
        send(32'h08052487, 32'h08052487, 1'b0);   // FLW offset 128, not encodable
        send(32'h00B50533, 32'h00B50533, 1'b0);   // ADD passthrough
        send(32'h00952227, 32'h0000_E144, 1'b1);  // FSW f9,4(x10) -> C.FSW
        send(32'h0FC12087, 32'h0000_70FE, 1'b1);  // FLW f1,252(x2) -> C.FLWSP
        send(32'h00252487, 32'h00252487, 1'b0);   // misaligned offset
        send(32'h00C52486, 32'h00C52486, 1'b0);   // low bits != 11
        send(32'h00C52087, 32'h00C52087, 1'b0);   // rd outside x8..x15
        send(32'h07C42407, 32'h0000_7C60, 1'b1);  // FLW f8,124(x8) max C.FLW offset
      end
      begin
        send2(32'h00512427, 32'h00512427, 1'b0);
        send2(32'h0FC12087, 32'h0FC12087, 1'b0);
        send2(32'h00C52487, 32'h0000_6544, 1'b1);
      end
    join
    drain();

    // Backpressure: two fill the FIFO, third waits until the first pop.
    out_ready = 1'b0;
    send(32'h11111113, 32'h11111113, 1'b0);
    send(32'h22222213, 32'h22222213, 1'b0);
    @(negedge clk);
    check("full_in_ready", {31'h0, in_ready}, 32'd0);
    check("full_level", {30'h0, level}, 32'd2);
    check("full_head_stable", out_instr, 32'h11111113);
    @(posedge clk); #1;
    fork
      send(32'h00C52487, 32'h0000_6544, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Simultaneous push and pop at level 1.
    out_ready = 1'b0;
    send(32'h33333313, 32'h33333313, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(32'h00000013 | (i << 20), 32'h00000013 | (i << 20), 1'b0);
      check("steady_level", {30'h0, level}, 32'd1);
      check("steady_in_ready", {31'h0, in_ready}, 32'd1);
    end
    drain();

    // Flush with a full FIFO and an input offered in the same cycle.
    out_ready = 1'b0;
    send(32'h44444413, 32'h44444413, 1'b0);
    send(32'h55555513, 32'h55555513, 1'b0);
    in_valid = 1'b1;
    in_instr = 32'h66666613;
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_level", {30'h0, level}, 32'd0);
    check("flush_out_valid", {31'h0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send(32'h00952227, 32'h0000_E144, 1'b1);
    drain();

    // Asynchronous reset mid-stream drops the head in the same cycle.
    out_ready = 1'b0;
    send(32'h77777713, 32'h77777713, 1'b0);
    send(32'h88888813, 32'h88888813, 1'b0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_reset_out_valid", {31'h0, out_valid}, 32'd0);
    check("async_reset_level", {30'h0, level}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h00512427, 32'h0000_E416, 1'b1);
    drain();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
